dmem_mmio: RTL

Data-side memory subsystem attached directly to the CPU's data port (daddr/drdata/dwdata/dwe). It consumes the MEM-stage address, write data and byte enables. It returns read data combinationally in the same cycle, which preserves the single-cycle MEM-stage load model. Addresses below MMIO_BASE map to a byte-writable RAM. Addresses at or above MMIO_BASE map to a small peripheral window: a TX FIFO with a valid/ready output, a 64-bit cycle counter and a halt register.

---
 rtl/dmem_mmio.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory for the CPU MEM stage: byte-writable RAM below MMIO_BASE and a
// peripheral window above it (TX FIFO, 64-bit cycle counter, sticky halt flag).
module dmem_mmio #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [31:0] OFF_TXDATA  = 32'h0000_0000;
    localparam logic [31:0] OFF_TXSTAT  = 32'h0000_0004;
    localparam logic [31:0] OFF_CYC_LO  = 32'h0000_0008;
    localparam logic [31:0] OFF_CYC_HI  = 32'h0000_000C;
    localparam logic [31:0] OFF_HALT    = 32'h0000_0010;

    logic [31:0]   r_ram  [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_halt;
    logic [63:0]   r_cycle;

    logic          w_is_mmio;
    logic [31:0]   w_off;
    logic [AW-1:0] w_ram_idx;
    logic [3:0]    w_ram_we;
    logic          w_tx_wr;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_halt_set;

    assign w_is_mmio  = (daddr >= MMIO_BASE);
    assign w_off      = daddr - MMIO_BASE;
    assign w_ram_idx  = daddr[AW+1:2];
    assign w_ram_we   = dwe & {4{~w_is_mmio}};

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == {CW{1'b0}});
    assign w_tx_wr    = w_is_mmio && (w_off == OFF_TXDATA) && dwe[0];
    assign w_pop      = ~w_empty & tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_tx_wr & (~w_full | w_pop);
    assign w_ovf_set  = w_tx_wr & w_full & ~w_pop;
    assign w_ovf_clr  = w_is_mmio && (w_off == OFF_TXSTAT) && dwe[0] && dwdata[2];
    assign w_halt_set = w_is_mmio && (w_off == OFF_HALT) && dwe[0] && dwdata[0];

    assign tx_valid = ~w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
    assign halt     = r_halt;

    // RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_ram_we[i]) begin
                r_ram[w_ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    // FIFO payload storage; the empty gate on tx_data hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= dwdata[7:0];
        end
    end

    // FIFO pointers/count, overflow, halt and cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rptr  <= {PW{1'b0}};
            r_wptr  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_ovf   <= 1'b0;
            r_halt  <= 1'b0;
            r_cycle <= 64'd0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_pop) begin
                r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_push) begin
                r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Combinational read mux keeps the single-cycle load path.
    always_comb begin
        drdata = 32'h0000_0000;
        if (!w_is_mmio) begin
            drdata = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                OFF_TXSTAT: drdata = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};
                OFF_CYC_LO: drdata = r_cycle[31:0];
                OFF_CYC_HI: drdata = r_cycle[63:32];
                OFF_HALT:   drdata = {31'h0000_0000, r_halt};
                default:    drdata = 32'h0000_0000;
            endcase
        end
    end

endmodule
